// File: rtl/chad_mem_arb.sv
// chad_mem_arb: shares one synchronous single-port data RAM between the chad CPU
// data port and a host/debug port.
// Latency: grant, h_ack and cpu_hold are combinational in the request cycle.
//   Read data arrives one cycle after the grant.
// Backpressure: the CPU has priority. The host waits until it has lost MAXWAIT
//   cycles, then forces a one-cycle CPU stall through cpu_hold. h_lock holds the CPU
//   unconditionally.
// Ports:
//   clk, resetq            clock (rising edge) and asynchronous active-low reset
//   cpu_rd/wr/addr/wdata   CPU data request; cpu_rdata, cpu_hold back to the CPU
//   h_req/we/addr/wdata    host request, held until h_ack
//   h_lock                 debug freeze
//   h_ack/rvalid/rdata     host responses
//   ram_*                  single-port RAM; ram_rdata is valid the cycle after a read
//   stall_cnt              saturating count of cpu_hold cycles
module chad_mem_arb #(
  parameter int WIDTH   = 18,
  parameter int AWIDTH  = 15,
  parameter int MAXWAIT = 4
) (
  input  logic              clk,
  input  logic              resetq,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [AWIDTH-1:0] cpu_addr,
  input  logic [WIDTH-1:0]  cpu_wdata,
  output logic [WIDTH-1:0]  cpu_rdata,
  output logic              cpu_hold,
  input  logic              h_req,
  input  logic              h_we,
  input  logic [AWIDTH-1:0] h_addr,
  input  logic [WIDTH-1:0]  h_wdata,
  input  logic              h_lock,
  output logic              h_ack,
  output logic              h_rvalid,
  output logic [WIDTH-1:0]  h_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [WIDTH-1:0]  ram_wdata,
  input  logic [WIDTH-1:0]  ram_rdata,
  output logic [15:0]       stall_cnt
);

  localparam logic [3:0] MAXW = 4'(MAXWAIT);

  logic              cpu_acc;
  logic              host_win;
  logic              cpu_win;

  logic [3:0]        wait_cnt_q,  wait_cnt_d;
  logic              cpu_rd_q,    cpu_rd_d;
  logic              h_rvalid_q,  h_rvalid_d;
  logic [WIDTH-1:0]  cpu_last_q,  cpu_last_d;
  logic [15:0]       stall_cnt_q, stall_cnt_d;

  always_comb begin
    cpu_acc  = cpu_rd | cpu_wr;
    // The host wins an idle CPU cycle, wins under lock, or forces its way in
    // once it has lost MAXWAIT cycles in a row.
    host_win = h_req & (~cpu_acc | h_lock | (wait_cnt_q == MAXW));
    cpu_win  = cpu_acc & ~host_win & ~h_lock;
    h_ack    = host_win;
    cpu_hold = h_lock | (cpu_acc & host_win);

    ram_en    = host_win | cpu_win;
    ram_we    = host_win ? h_we : (cpu_win & cpu_wr);
    // With no winner the address and data buses rest on the CPU inputs.
    ram_addr  = host_win ? h_addr  : cpu_addr;
    ram_wdata = host_win ? h_wdata : cpu_wdata;

    wait_cnt_d = wait_cnt_q;
    if (!h_req || host_win) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q != MAXW) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end

    // When cpu_rd and cpu_wr are both high, the access is a write and returns no read data.
    cpu_rd_d   = cpu_win & cpu_rd & ~cpu_wr;
    h_rvalid_d = host_win & ~h_we;

    // Capture the CPU's read result so it stays put across host cycles and stalls.
    cpu_last_d = cpu_rd_q ? ram_rdata : cpu_last_q;

    stall_cnt_d = stall_cnt_q;
    if (cpu_hold && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      wait_cnt_q  <= '0;
      cpu_rd_q    <= 1'b0;
      h_rvalid_q  <= 1'b0;
      cpu_last_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      cpu_rd_q    <= cpu_rd_d;
      h_rvalid_q  <= h_rvalid_d;
      cpu_last_q  <= cpu_last_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign cpu_rdata = cpu_rd_q ? ram_rdata : cpu_last_q;
  assign h_rvalid  = h_rvalid_q;
  assign h_rdata   = ram_rdata;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_chad_mem_arb.sv
// Directed testbench for chad_mem_arb with a behavioural synchronous RAM.
// Inputs change 1 ns after a rising edge, and outputs are checked 1 ns later.
// A preload port writes the RAM contents while the design is in reset.
module tb_chad_mem_arb;

  logic        clk = 1'b0;
  logic        resetq;
  logic        cpu_rd, cpu_wr;
  logic [14:0] cpu_addr;
  logic [17:0] cpu_wdata, cpu_rdata;
  logic        cpu_hold;
  logic        h_req, h_we, h_lock, h_ack, h_rvalid;
  logic [14:0] h_addr;
  logic [17:0] h_wdata, h_rdata;
  logic        ram_en, ram_we;
  logic [14:0] ram_addr;
  logic [17:0] ram_wdata, ram_rdata;
  logic [15:0] stall_cnt;

  logic        pl_we;
  logic [14:0] pl_addr;
  logic [17:0] pl_dat;
  logic [17:0] mem [0:32767];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  chad_mem_arb #(.WIDTH(18), .AWIDTH(15), .MAXWAIT(4)) dut (
    .clk(clk), .resetq(resetq),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_hold(cpu_hold),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata), .h_lock(h_lock),
    .h_ack(h_ack), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .stall_cnt(stall_cnt)
  );

  always @(posedge clk) begin
    if (pl_we) begin
      mem[pl_addr] <= pl_dat;
    end else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [14:0] a, input logic [17:0] d);
    pl_we = 1'b1; pl_addr = a; pl_dat = d;
    tick;
    pl_we = 1'b0;
  endtask

  initial begin
    resetq = 1'b0;
    cpu_rd = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0;
    h_req = 0; h_we = 0; h_addr = '0; h_wdata = '0; h_lock = 0;
    pl_we = 0; pl_addr = '0; pl_dat = '0;
    tick;
    preload(15'h0010, 18'h2ABCD);
    preload(15'h0100, 18'h12345);
    preload(15'h0020, 18'h3FFFF);
    #1;
    chk("rst_cpu_rdata", 32'(cpu_rdata), 32'h0);
    chk("rst_h_rvalid",  32'(h_rvalid),  32'h0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'h0);
    chk("rst_cpu_hold",  32'(cpu_hold),  32'h0);
    chk("rst_ram_en",    32'(ram_en),    32'h0);
    tick;
    resetq = 1'b1;

    // CPU-only read of 0x0010, then hold the data across idle cycles.
    tick;
    cpu_rd = 1; cpu_addr = 15'h0010;
    #1;
    chk("t1_ram_en",   32'(ram_en),   32'h1);
    chk("t1_ram_we",   32'(ram_we),   32'h0);
    chk("t1_ram_addr", 32'(ram_addr), 32'h0010);
    chk("t1_cpu_hold", 32'(cpu_hold), 32'h0);
    tick;
    cpu_rd = 0;
    #1;
    chk("t1_rdata", 32'(cpu_rdata), 32'h2ABCD);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("t1_rdata_idle", 32'(cpu_rdata), 32'h2ABCD);
      chk("t1_hold_idle",  32'(cpu_hold),  32'h0);
    end

    // Host read while the CPU is idle.
    h_req = 1; h_we = 0; h_addr = 15'h0100;
    #1;
    chk("t2_h_ack",    32'(h_ack),    32'h1);
    chk("t2_ram_addr", 32'(ram_addr), 32'h0100);
    tick;
    h_req = 0;
    #1;
    chk("t2_h_rvalid",  32'(h_rvalid),  32'h1);
    chk("t2_h_rdata",   32'(h_rdata),   32'h12345);
    chk("t2_cpu_rdata", 32'(cpu_rdata), 32'h2ABCD);
    tick;
    chk("t2_rvalid_off", 32'(h_rvalid), 32'h0);

    // Host starved by continuous CPU reads; forced grant on the 5th cycle.
    cpu_rd = 1; cpu_addr = 15'h0010; h_req = 1; h_we = 0; h_addr = 15'h0100;
    for (int c = 1; c <= 5; c++) begin
      #1;
      chk("t3_h_ack",    32'(h_ack),    (c == 5) ? 32'h1 : 32'h0);
      chk("t3_cpu_hold", 32'(cpu_hold), (c == 5) ? 32'h1 : 32'h0);
      if (c < 5) tick;
    end
    tick;
    chk("t3_ack_after",  32'(h_ack),     32'h0);
    chk("t3_h_rvalid",   32'(h_rvalid),  32'h1);
    chk("t3_h_rdata",    32'(h_rdata),   32'h12345);
    chk("t3_stall_cnt",  32'(stall_cnt), 32'h1);
    chk("t3_cpu_rdata",  32'(cpu_rdata), 32'h2ABCD);
    h_req = 0; cpu_rd = 0;

    // CPU read of 0x3FFFF pending while the host writes 0x00ABC to 0x0005.
    tick;
    cpu_rd = 1; cpu_addr = 15'h0020;
    #1;
    chk("t4_cpu_grant", 32'(ram_en), 32'h1);
    tick;
    cpu_rd = 0; h_req = 1; h_we = 1; h_addr = 15'h0005; h_wdata = 18'h00ABC;
    #1;
    chk("t4_h_ack",     32'(h_ack),     32'h1);
    chk("t4_ram_we",    32'(ram_we),    32'h1);
    chk("t4_cpu_hold",  32'(cpu_hold),  32'h0);
    chk("t4_rdata_a",   32'(cpu_rdata), 32'h3FFFF);
    tick;
    h_req = 0; h_we = 0;
    #1;
    chk("t4_rdata_b",   32'(cpu_rdata), 32'h3FFFF);
    chk("t4_no_rvalid", 32'(h_rvalid),  32'h0);
    // Both cpu_rd and cpu_wr high: write wins, no read data returned.
    cpu_rd = 1; cpu_wr = 1; cpu_addr = 15'h0007; cpu_wdata = 18'h11111;
    #1;
    chk("t4_rdwr_we", 32'(ram_we), 32'h1);
    tick;
    cpu_rd = 0; cpu_wr = 0;
    #1;
    chk("t4_rdwr_rdata", 32'(cpu_rdata), 32'h3FFFF);
    tick;
    cpu_rd = 1; cpu_addr = 15'h0005;
    tick;
    cpu_rd = 0;
    #1;
    chk("t4_readback", 32'(cpu_rdata), 32'h00ABC);

    // Debug lock for 10 cycles with back-to-back host reads.
    tick;
    h_lock = 1;
    for (int i = 0; i < 10; i++) begin
      h_req = 1; h_we = 0; h_addr = i[0] ? 15'h0010 : 15'h0100;
      #1;
      chk("t5_cpu_hold", 32'(cpu_hold), 32'h1);
      chk("t5_h_ack",    32'(h_ack),    32'h1);
      if (i > 0) begin
        chk("t5_h_rvalid", 32'(h_rvalid), 32'h1);
        chk("t5_h_rdata",  32'(h_rdata),  i[0] ? 32'h12345 : 32'h2ABCD);
      end
      tick;
    end
    h_lock = 0; h_req = 0;
    #1;
    // One stall from the forced host grant earlier, plus ten locked cycles.
    chk("t5_stall_cnt", 32'(stall_cnt), 32'd11);
    chk("t5_last_rd",   32'(h_rdata),   32'h2ABCD);
    chk("t5_released",  32'(cpu_hold),  32'h0);

    // Reset lands the cycle after a host read grant.
    tick;
    h_req = 1; h_we = 0; h_addr = 15'h0100;
    #1;
    chk("t6_h_ack", 32'(h_ack), 32'h1);
    tick;
    h_req = 0;
    chk("t6_rvalid_pre", 32'(h_rvalid), 32'h1);
    cpu_rd = 1; cpu_addr = 15'h0010;
    resetq = 1'b0;
    #1;
    chk("t6_h_rvalid",  32'(h_rvalid),  32'h0);
    chk("t6_stall_cnt", 32'(stall_cnt), 32'h0);
    chk("t6_cpu_rdata", 32'(cpu_rdata), 32'h0);
    chk("t6_comb_en",   32'(ram_en),    32'h1);
    chk("t6_comb_hold", 32'(cpu_hold),  32'h0);
    tick;
    resetq = 1'b1;
    cpu_rd = 0;
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
